// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction refill (0) and data cache (1).
// Define MEM_ARB_PERF_EN to add saturating grant and stall counters.
module mem_port_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [1:0]            req_i,
   input  logic                  we0_i,
   input  logic                  we1_i,
   input  logic [ADDR_WIDTH-1:0] addr0_i,
   input  logic [ADDR_WIDTH-1:0] addr1_i,
   input  logic [DATA_WIDTH-1:0] wdata0_i,
   input  logic [DATA_WIDTH-1:0] wdata1_i,
   output logic [1:0]            gnt_o,
   output logic [1:0]            rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata0_o,
   output logic [DATA_WIDTH-1:0] rdata1_o,
   output logic                  owner_o,
   output logic                  busy_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_ack_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [15:0]           gnt_cnt0_o,
   output logic [15:0]           gnt_cnt1_o,
   output logic [15:0]           stall_cnt_o
`endif
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e                state_q, state_d;
   logic                  last_owner_q, owner_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
   logic [DATA_WIDTH-1:0] cap_data;
   logic                  winner;
   logic                  grant_evt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (|req_i) state_d = StBusy;
         StBusy:  if (mem_ack_i) state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // A tie goes to whoever did not own the port last.
   always_comb begin
      unique case (req_i)
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last_owner_q;
         default: winner = 1'b0;
      endcase
   end

   assign grant_evt = (state_q == StIdle) && (|req_i);

   always_comb begin
      gnt_o     = 2'b00;
      rvalid_o  = 2'b00;
      mem_req_o = 1'b0;
      busy_o    = 1'b0;
      unique case (state_q)
         StIdle: if (|req_i) gnt_o[winner] = 1'b1;
         StBusy: begin
            mem_req_o = 1'b1;
            busy_o    = 1'b1;
         end
         StResp: begin
            busy_o            = 1'b1;
            rvalid_o[owner_q] = 1'b1;
         end
         default: ;
      endcase
   end

   assign cap_data = mem_we_q ? '0 : mem_rdata_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_owner_q <= 1'b1;
         owner_q      <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         if (grant_evt) begin
            owner_q      <= winner;
            last_owner_q <= winner;
            mem_we_q     <= winner ? we1_i : we0_i;
            mem_addr_q   <= winner ? addr1_i : addr0_i;
            mem_wdata_q  <= winner ? wdata1_i : wdata0_i;
         end
         if (state_q == StBusy && mem_ack_i) begin
            rdata0_q <= owner_q ? '0 : cap_data;
            rdata1_q <= owner_q ? cap_data : '0;
         end
      end
   end

   assign owner_o     = owner_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign rdata0_o    = rdata0_q;
   assign rdata1_o    = rdata1_q;

`ifdef MEM_ARB_PERF_EN
   logic [15:0] gnt_cnt0_q, gnt_cnt1_q, stall_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gnt_cnt0_q  <= '0;
         gnt_cnt1_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (gnt_o[0] && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
         if (gnt_o[1] && gnt_cnt1_q != 16'hFFFF) gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
         if ((|req_i) && (gnt_o == 2'b00) && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign gnt_cnt0_o  = gnt_cnt0_q;
   assign gnt_cnt1_o  = gnt_cnt1_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: read, write, busy blocking, async reset, round-robin ties.
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic        we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [1:0]  gnt, rvalid;
   logic [31:0] rdata0, rdata1;
   logic        owner, busy, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
   logic [15:0] gnt_cnt0, gnt_cnt1, stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_i      (req),
      .we0_i      (we0),
      .we1_i      (we1),
      .addr0_i    (addr0),
      .addr1_i    (addr1),
      .wdata0_i   (wdata0),
      .wdata1_i   (wdata1),
      .gnt_o      (gnt),
      .rvalid_o   (rvalid),
      .rdata0_o   (rdata0),
      .rdata1_o   (rdata1),
      .owner_o    (owner),
      .busy_o     (busy),
      .mem_req_o  (mem_req),
      .mem_we_o   (mem_we),
      .mem_addr_o (mem_addr),
      .mem_wdata_o(mem_wdata),
      .mem_ack_i  (mem_ack),
      .mem_rdata_i(mem_rdata)
`ifdef MEM_ARB_PERF_EN
      ,
      .gnt_cnt0_o (gnt_cnt0),
      .gnt_cnt1_o (gnt_cnt1),
      .stall_cnt_o(stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; checks follow a further #2 settle.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; req = 2'b00; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      #2;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rdata0", rdata0, 32'h0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();

      // Single read, ack three cycles after mem_req rises.
      req = 2'b01; addr0 = 32'h100; #2;
      chk("rd_gnt_c0", 32'(gnt), 32'h1);
      chk("rd_busy_c0", 32'(busy), 32'h0);
      cyc(); req = 2'b00; #2;
      chk("rd_mem_req_c1", 32'(mem_req), 32'h1);
      chk("rd_addr_c1", mem_addr, 32'h100);
      chk("rd_gnt_c1", 32'(gnt), 32'h0);
      cyc(); #2;
      chk("rd_addr_c2", mem_addr, 32'h100);
      cyc(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #2;
      chk("rd_addr_c3", mem_addr, 32'h100);
      chk("rd_rvalid_c3", 32'(rvalid), 32'h0);
      cyc(); mem_ack = 1'b0; #2;
      chk("rd_rvalid_c4", 32'(rvalid), 32'h1);
      chk("rd_rdata0", rdata0, 32'hDEADBEEF);
      chk("rd_rdata1", rdata1, 32'h0);
      chk("rd_mem_req_c4", 32'(mem_req), 32'h0);
      cyc(); #2;
      chk("rd_rvalid_c5", 32'(rvalid), 32'h0);
      chk("rd_rdata0_hold", rdata0, 32'hDEADBEEF);
      chk("rd_busy_c5", 32'(busy), 32'h0);

      // mem_ack while idle is ignored.
      mem_ack = 1'b1; cyc(); mem_ack = 1'b0; #2;
      chk("ack_idle_busy", 32'(busy), 32'h0);
      chk("ack_idle_rvalid", 32'(rvalid), 32'h0);

      // Write from requester 1 with immediate ack; read data lane forced to zero.
      req = 2'b10; we1 = 1'b1; wdata1 = 32'h12345678; addr1 = 32'h40; mem_rdata = 32'hFFFFFFFF;
      #2;
      chk("wr_gnt", 32'(gnt), 32'h2);
      cyc(); req = 2'b00; mem_ack = 1'b1; #2;
      chk("wr_mem_req", 32'(mem_req), 32'h1);
      chk("wr_mem_we", 32'(mem_we), 32'h1);
      chk("wr_mem_wdata", mem_wdata, 32'h12345678);
      chk("wr_mem_addr", mem_addr, 32'h40);
      chk("wr_owner", 32'(owner), 32'h1);
      cyc(); mem_ack = 1'b0; we1 = 1'b0; #2;
      chk("wr_rvalid", 32'(rvalid), 32'h2);
      chk("wr_rdata1", rdata1, 32'h0);
      chk("wr_rdata0", rdata0, 32'h0);
      cyc(); #2;
      chk("wr_owner_hold", 32'(owner), 32'h1);

      // Requester 1 arrives while requester 0 is busy.
      req = 2'b01; addr0 = 32'h200; addr1 = 32'h300; #2;
      chk("bz_gnt0", 32'(gnt), 32'h1);
      cyc(); req = 2'b10; #2;
      chk("bz_gnt_busy1", 32'(gnt), 32'h0);
      chk("bz_addr1", mem_addr, 32'h200);
      cyc(); mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5; #2;
      chk("bz_gnt_busy2", 32'(gnt), 32'h0);
      chk("bz_addr2", mem_addr, 32'h200);
      cyc(); mem_ack = 1'b0; #2;
      chk("bz_gnt_resp", 32'(gnt), 32'h0);
      chk("bz_rvalid0", 32'(rvalid), 32'h1);
      chk("bz_rdata0", rdata0, 32'hA5A5A5A5);
      cyc(); #2;
      chk("bz_gnt1", 32'(gnt), 32'h2);
      cyc(); req = 2'b01; #2;
      chk("bz_addr_r1", mem_addr, 32'h300);
      cyc(); req = 2'b00; mem_ack = 1'b1; mem_rdata = 32'h0BADF00D; #2;
      cyc(); mem_ack = 1'b0; #2;
      chk("bz_rvalid1", 32'(rvalid), 32'h2);
      chk("bz_rdata1", rdata1, 32'h0BADF00D);
      chk("bz_rdata0_zero", rdata0, 32'h0);
      cyc(); #2;
      // req0 pulsed and withdrawn during BUSY: nothing issued.
      chk("wd_gnt", 32'(gnt), 32'h0);
      cyc(); #2;
      chk("wd_busy", 32'(busy), 32'h0);

      // Async reset mid-transaction.
      req = 2'b01; addr0 = 32'h500; cyc(); req = 2'b00; #2;
      chk("mr_mem_req_pre", 32'(mem_req), 32'h1);
      rst_n = 1'b0; #1;
      chk("mr_mem_req", 32'(mem_req), 32'h0);
      chk("mr_busy", 32'(busy), 32'h0);
      chk("mr_gnt", 32'(gnt), 32'h0);
      chk("mr_rvalid", 32'(rvalid), 32'h0);
      chk("mr_owner", 32'(owner), 32'h0);
      cyc(); cyc();
      rst_n = 1'b1; req = 2'b11; addr0 = 32'h600; addr1 = 32'h700;

      // Tie after reset: strict alternation starting with requester 0.
      for (int i = 0; i < 5; i++) begin
         logic exp_own;
         exp_own = i[0];
         #2;
         chk("tie_gnt", 32'(gnt), exp_own ? 32'h2 : 32'h1);
         chk("tie_rvalid_idle", 32'(rvalid), 32'h0);
         cyc();
         if (i == 4) req = 2'b00;
         mem_ack = 1'b1; mem_rdata = 32'h1000 + 32'(i); #2;
         chk("tie_owner", 32'(owner), 32'(exp_own));
         chk("tie_addr", mem_addr, exp_own ? 32'h700 : 32'h600);
         chk("tie_gnt_busy", 32'(gnt), 32'h0);
         cyc(); mem_ack = 1'b0; #2;
         chk("tie_rvalid", 32'(rvalid), exp_own ? 32'h2 : 32'h1);
         chk("tie_lane", exp_own ? rdata1 : rdata0, 32'h1000 + 32'(i));
         chk("tie_other", exp_own ? rdata0 : rdata1, 32'h0);
         cyc();
      end

`ifdef MEM_ARB_PERF_EN
      #2;
      chk("perf_gnt0", 32'(gnt_cnt0), 32'd3);
      chk("perf_gnt1", 32'(gnt_cnt1), 32'd2);
      chk("perf_stall", 32'(stall_cnt), 32'd8);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
